fb_pixel_writer: RTL and testbench

//  Write side of the VGA frame buffer: takes pixel/rectangle/clear draw commands over a

---
 rtl/fb_pixel_writer.sv | 185 ++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write engine: PIXEL/FILL/CLEAR commands become RGB555 writes at 160x120.
// Optional VBLANK_SYNC_EN holds each new write request until vblank_i is high.
module fb_pixel_writer #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 16,
    parameter int BASE_ADDR   = 10000,
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int COORD_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [COORD_WIDTH-1:0] cmd_x0_i,
    input  logic [COORD_WIDTH-1:0] cmd_y0_i,
    input  logic [COORD_WIDTH-1:0] cmd_x1_i,
    input  logic [COORD_WIDTH-1:0] cmd_y1_i,
    input  logic [23:0]            cmd_color_i,
    output logic                   mem_valid_o,
    input  logic                   mem_ready_i,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0]  mem_data_o,
    input  logic                   vblank_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_DONE, S_ERR
    } state_e;

    localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(FB_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(FB_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0]  BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0]  ROW_A  = ADDR_WIDTH'(FB_WIDTH);

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  row_q, row_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [COORD_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [COORD_WIDTH-1:0] x1_q, x1_d, y1_q, y1_d;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                   rsv_q, rsv_d;
    logic                   bad;
    logic                   gate;
    logic                   unused_color;

`ifdef VBLANK_SYNC_EN
    assign gate = vblank_i;
`else
    logic unused_vblank;
    assign unused_vblank = vblank_i;
    assign gate = 1'b1;
`endif

    assign unused_color = ^{cmd_color_i[18:16], cmd_color_i[10:8],
                            cmd_color_i[2:0]};

    assign bad = rsv_q || (x0_q > x1_q) || (y0_q > y1_q)
              || (x1_q > X_MAX) || (y1_q > Y_MAX);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        row_d   = row_q;
        data_d  = data_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x_d     = x_q;
        y_d     = y_q;
        rsv_d   = rsv_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    state_d = S_CHECK;
                    data_d  = DATA_WIDTH'({1'b0, cmd_color_i[7:3],
                                           cmd_color_i[15:11],
                                           cmd_color_i[23:19]});
                    rsv_d   = (cmd_op_i == 2'b11);
                    x0_d    = cmd_x0_i;
                    y0_d    = cmd_y0_i;
                    x1_d    = cmd_x1_i;
                    y1_d    = cmd_y1_i;
                    if (cmd_op_i == 2'b00) begin
                        x1_d = cmd_x0_i;
                        y1_d = cmd_y0_i;
                    end else if (cmd_op_i == 2'b10) begin
                        x0_d = '0;
                        y0_d = '0;
                        x1_d = X_MAX;
                        y1_d = Y_MAX;
                    end
                end
            end
            S_CHECK: begin
                if (bad) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WRITE;
                    x_d     = x0_q;
                    y_d     = y0_q;
                    // constant-coefficient product folds into shift/add
                    row_d   = BASE_A + ADDR_WIDTH'(y0_q) * ROW_A;
                    addr_d  = row_d + ADDR_WIDTH'(x0_q);
                    valid_d = gate;
                end
            end
            S_WRITE: begin
                if (valid_q && mem_ready_i) begin
                    if (x_q == x1_q && y_q == y1_q) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end else if (x_q == x1_q) begin
                        x_d     = x0_q;
                        y_d     = y_q + 1'b1;
                        row_d   = row_q + ROW_A;
                        addr_d  = row_d + ADDR_WIDTH'(x0_q);
                        valid_d = gate;
                    end else begin
                        x_d     = x_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        valid_d = gate;
                    end
                end else if (!valid_q) begin
                    valid_d = gate;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready_d = (state_d == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
            data_q  <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rsv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            data_q  <= data_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rsv_q   <= rsv_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed + random bench for fb_pixel_writer against a rectangle-walk model.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [7:0]  cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i;
    logic [23:0] cmd_color_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [14:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic        vblank_i;
    logic        busy_o, done_o, err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_pixel_writer dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i),
        .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i),
        .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
        .cmd_color_i(cmd_color_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .vblank_i(vblank_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op,
                           input logic [7:0] ax0, input logic [7:0] ay0,
                           input logic [7:0] ax1, input logic [7:0] ay1,
                           input logic [23:0] col,
                           input int pct, input int stall0);
        int ex0, ey0, ex1, ey1;
        bit rej, hs_prev, pv_stall, got_done;
        int exp_a[$];
        logic [15:0] ed;
        logic [14:0] pa;
        logic [15:0] pd;
        int beats, stalls, bound, w;
        ex0 = ax0; ey0 = ay0; ex1 = ax1; ey1 = ay1;
        if (op == 2'b00) begin ex1 = ex0; ey1 = ey0; end
        if (op == 2'b10) begin ex0 = 0; ey0 = 0; ex1 = 159; ey1 = 119; end
        rej = (op == 2'b11) || ex0 > ex1 || ey0 > ey1 || ex1 >= 160 || ey1 >= 120;
        if (!rej)
            for (int y = ey0; y <= ey1; y++)
                for (int x = ex0; x <= ex1; x++)
                    exp_a.push_back(10000 + y * 160 + x);
        ed = {1'b0, col[7:3], col[15:11], col[23:19]};
        w = 0;
        while (!cmd_ready_o && w < 50) begin @(negedge clk); w++; end
        chk("ready_wait", 48'(cmd_ready_o), 48'd1);
        cmd_op_i = op; cmd_x0_i = ax0; cmd_y0_i = ay0;
        cmd_x1_i = ax1; cmd_y1_i = ay1; cmd_color_i = col;
        cmd_valid_i = 1'b1; mem_ready_i = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("check_state", 48'({busy_o, mem_valid_o, cmd_ready_o, done_o}),
            48'b1000);
        bound = exp_a.size() * (pct < 100 ? 10 : 1) + stall0 + 20;
        beats = 0; stalls = 0; hs_prev = 0; pv_stall = 0; got_done = 0;
        pa = '0; pd = '0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_valid", 48'(mem_valid_o), 48'(!rej));
            if (pv_stall)
                chk("hold", 48'({mem_valid_o, mem_addr_o, mem_data_o}),
                    48'({1'b1, pa, pd}));
            if (done_o) begin
                got_done = 1;
                chk("err", 48'(err_o), 48'(rej));
                chk("beats", 48'(beats), 48'(exp_a.size()));
                if (!rej) chk("done_lat", 48'(hs_prev), 48'd1);
                break;
            end
            if (beats == 0 && stalls < stall0) begin
                mem_ready_i = 1'b0; stalls++;
            end else begin
                mem_ready_i = ($urandom_range(1, 100) <= pct);
            end
            hs_prev = 0; pv_stall = 0;
            if (mem_valid_o) begin
                if (mem_ready_i) begin
                    if (beats < exp_a.size())
                        chk("addr", 48'(mem_addr_o), 48'(exp_a[beats]));
                    else
                        chk("overrun", 48'(beats), 48'(exp_a.size() - 1));
                    chk("data", 48'(mem_data_o), 48'(ed));
                    beats++; hs_prev = 1;
                end else begin
                    pv_stall = 1; pa = mem_addr_o; pd = mem_data_o;
                end
            end
        end
        chk("done_seen", 48'(got_done), 48'd1);
        mem_ready_i = 1'b0;
        @(negedge clk);
        chk("post_done", 48'({done_o, err_o, cmd_ready_o, busy_o}), 48'b0010);
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] x0, y0;
        rst = 1'b1; cmd_valid_i = 1'b0; mem_ready_i = 1'b0; vblank_i = 1'b1;
        cmd_op_i = '0; cmd_x0_i = '0; cmd_y0_i = '0; cmd_x1_i = '0;
        cmd_y1_i = '0; cmd_color_i = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 48'({cmd_ready_o, mem_valid_o, busy_o, done_o,
                               err_o, mem_addr_o, mem_data_o}), 48'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 48'(cmd_ready_o), 48'd1);

        run_cmd(2'b00, 8'd3, 8'd2, 8'd0, 8'd0, 24'hFF0000, 100, 0);
        run_cmd(2'b01, 8'd158, 8'd118, 8'd159, 8'd119, 24'h00FF00, 100, 0);
        run_cmd(2'b01, 8'd0, 8'd0, 8'd1, 8'd0, 24'h123456, 100, 3);
        run_cmd(2'b01, 8'd5, 8'd0, 8'd4, 8'd0, 24'hFFFFFF, 100, 0);
        run_cmd(2'b00, 8'd160, 8'd0, 8'd0, 8'd0, 24'hFFFFFF, 100, 0);
        run_cmd(2'b00, 8'd0, 8'd120, 8'd0, 8'd0, 24'hFFFFFF, 100, 0);
        run_cmd(2'b11, 8'd0, 8'd0, 8'd1, 8'd1, 24'hFFFFFF, 100, 0);
        run_cmd(2'b10, 8'd9, 8'd9, 8'd1, 8'd1, 24'h0000FF, 100, 0);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10) op = 2'b01;
            x0 = 8'($urandom_range(0, 165));
            y0 = 8'($urandom_range(0, 124));
            run_cmd(op, x0, y0, 8'(x0 + $urandom_range(0, 6) - 1),
                    8'(y0 + $urandom_range(0, 4) - 1),
                    24'($urandom), $urandom_range(40, 100), 0);
        end

        cmd_op_i = 2'b01; cmd_x0_i = 8'd0; cmd_y0_i = 8'd0;
        cmd_x1_i = 8'd9; cmd_y1_i = 8'd9; cmd_color_i = 24'hABCDEF;
        cmd_valid_i = 1'b1; mem_ready_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_fill_busy", 48'({busy_o, mem_valid_o}), 48'b11);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 48'({mem_valid_o, busy_o, done_o, cmd_ready_o}),
            48'd0);
        @(negedge clk);
        rst = 1'b0; mem_ready_i = 1'b0;
        #1 chk("rst_ready_low", 48'(cmd_ready_o), 48'd0);
        @(negedge clk);
        chk("rst_ready_high", 48'({cmd_ready_o, busy_o, done_o}), 48'b100);
        run_cmd(2'b00, 8'd159, 8'd119, 8'd0, 8'd0, 24'h808080, 100, 0);

`ifdef VBLANK_SYNC_EN
        vblank_i = 1'b0;
        cmd_op_i = 2'b00; cmd_x0_i = 8'd1; cmd_y0_i = 8'd1;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0; mem_ready_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("vblank_gate", 48'(mem_valid_o), 48'd0);
        end
        vblank_i = 1'b1;
        @(negedge clk);
        chk("vblank_addr", 48'({mem_valid_o, mem_addr_o}),
            48'({1'b1, 15'd10161}));
        @(negedge clk);
        chk("vblank_done", 48'(done_o), 48'd1);
        mem_ready_i = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
